// File: rtl/mul_issue_wb.sv
// Issue/writeback adapter around the iterative multiplier: accepts M-extension
// multiply requests, starts the multiplier, and returns the selected product half.
// Optional result cache enabled by defining MUL_RESULT_CACHE_EN.
module mul_issue_wb #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  input  logic             mul_inready,
  output logic             mul_invalid,
  output logic             mul_flush,
  output logic [1:0]       mul_signed,
  output logic [XLEN-1:0]  mul_multiplicand,
  output logic [XLEN-1:0]  mul_multiplier,
  input  logic             mul_outvalid,
  input  logic [XLEN-1:0]  mul_result_hi,
  input  logic [XLEN-1:0]  mul_result_lo,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic [1:0]       dbg_state
);

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid and ready are both 1; a valid payload stays stable until then.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;

  state_t state_q, state_d;
  logic   op_is_mul_q;
  logic   accept;
  logic   capture_res;
  logic   hit;
  logic [XLEN-1:0] hit_data;

  function automatic logic [1:0] sign_of(input logic [1:0] op);
    case (op)
      2'b10:   sign_of = 2'b10;
      2'b11:   sign_of = 2'b00;
      default: sign_of = 2'b11;
    endcase
  endfunction

`ifdef MUL_RESULT_CACHE_EN
  logic            cache_valid;
  logic [XLEN-1:0] cache_rs1;
  logic [XLEN-1:0] cache_rs2;
  logic [1:0]      cache_signed;
  logic [XLEN-1:0] cache_hi;
  logic [XLEN-1:0] cache_lo;

  // The low half does not depend on signedness, so MUL hits regardless of it.
  assign hit = cache_valid && (req_rs1 == cache_rs1) && (req_rs2 == cache_rs2) &&
               ((req_op == OP_MUL) || (sign_of(req_op) == cache_signed));
  assign hit_data = (req_op == OP_MUL) ? cache_lo : cache_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid  <= 1'b0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_signed <= 2'b00;
      cache_hi     <= '0;
      cache_lo     <= '0;
    end else if (flush) begin
      cache_valid <= 1'b0;
    end else if (capture_res) begin
      cache_valid  <= 1'b1;
      cache_rs1    <= mul_multiplicand;
      cache_rs2    <= mul_multiplier;
      cache_signed <= mul_signed;
      cache_hi     <= mul_result_hi;
      cache_lo     <= mul_result_lo;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    mul_invalid = 1'b0;
    mul_flush   = 1'b0;
    accept      = 1'b0;
    capture_res = 1'b0;

    case (state_q)
      S_IDLE:  req_ready = !flush;
      S_ISSUE: mul_invalid = mul_inready && !flush;
      S_RESP:  req_ready = wb_ready && !flush;
      default: ;
    endcase

    accept      = req_valid && req_ready;
    mul_flush   = flush && ((state_q == S_ISSUE) || (state_q == S_WAIT));
    capture_res = (state_q == S_WAIT) && mul_outvalid && !flush;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = hit ? S_RESP : S_ISSUE;
        S_ISSUE: if (mul_invalid) state_d = S_WAIT;
        S_WAIT:  if (mul_outvalid) state_d = S_RESP;
        S_RESP: begin
          if (accept)        state_d = hit ? S_RESP : S_ISSUE;
          else if (wb_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign wb_valid  = (state_q == S_RESP);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      op_is_mul_q      <= 1'b0;
      mul_signed       <= 2'b00;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      wb_tag           <= '0;
      wb_data          <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_is_mul_q      <= (req_op == OP_MUL);
        mul_signed       <= sign_of(req_op);
        mul_multiplicand <= req_rs1;
        mul_multiplier   <= req_rs2;
        wb_tag           <= req_tag;
        if (hit) wb_data <= hit_data;
      end
      if (capture_res) wb_data <= op_is_mul_q ? mul_result_lo : mul_result_hi;
    end
  end

endmodule
